// File: rtl/lstm_seq_ctrl.sv
// Sequencer for lstm_top: buffers input vectors, runs one lstm step per vector and
// feeds each captured y_out back as the recurrent hidden state h.
module lstm_seq_ctrl #(
  parameter int DATA_WIDTH   = 8,
  parameter int LANES        = 4,
  parameter int MAX_LEN      = 8,
  parameter int START_CYCLES = 2,
  parameter int TIMEOUT      = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [LANES*DATA_WIDTH-1:0]   in_data,
  input  logic                          seq_start,
  input  logic                          keep_state,
  output logic                          busy,
  output logic                          done,
  output logic                          timeout_err,
  output logic [LANES*DATA_WIDTH-1:0]   h_out,
  output logic                          lstm_start,
  output logic [LANES*DATA_WIDTH-1:0]   lstm_x,
  output logic [LANES*DATA_WIDTH-1:0]   lstm_y_in,
  input  logic                          lstm_finished,
  input  logic [LANES*DATA_WIDTH-1:0]   lstm_y_out
);

  localparam int VW  = LANES * DATA_WIDTH;
  localparam int CW  = $clog2(MAX_LEN + 1);
  localparam int IW  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int SCW = $clog2(START_CYCLES + 1);
  localparam int WCW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    wr_cnt_q, wr_cnt_d;
  logic [CW-1:0]    len_q, len_d;
  logic [IW-1:0]    t_q, t_d;
  logic [VW-1:0]    h_q, h_d;
  logic [VW-1:0]    vec_buf_q [MAX_LEN];
  logic [VW-1:0]    vec_buf_d [MAX_LEN];
  logic [SCW-1:0]   start_cnt_q, start_cnt_d;
  logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
  logic             finished_q;
  logic             lstm_start_q, lstm_start_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             timeout_err_q, timeout_err_d;
  logic             finished_edge;
  logic             last_step;

  assign in_ready      = (state_q == IDLE) && (wr_cnt_q < CW'(MAX_LEN)) && !seq_start;
  // Only a fresh rising edge counts, so a finished level left over from before WAIT is ignored.
  assign finished_edge = lstm_finished && !finished_q;
  assign last_step     = (CW'(t_q) + CW'(1)) == len_q;

  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout_err = timeout_err_q;
  assign lstm_start  = lstm_start_q;
  assign h_out       = h_q;
  assign lstm_y_in   = h_q;
  assign lstm_x      = vec_buf_q[t_q];

  always_comb begin
    state_d       = state_q;
    wr_cnt_d      = wr_cnt_q;
    len_d         = len_q;
    t_d           = t_q;
    h_d           = h_q;
    vec_buf_d     = vec_buf_q;
    start_cnt_d   = start_cnt_q;
    wait_cnt_d    = wait_cnt_q;
    lstm_start_d  = lstm_start_q;
    busy_d        = busy_q;
    done_d        = done_q;
    timeout_err_d = timeout_err_q;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          vec_buf_d[wr_cnt_q[IW-1:0]] = in_data;
          wr_cnt_d                    = wr_cnt_q + CW'(1);
        end
        if (seq_start && (wr_cnt_q != '0)) begin
          len_d         = wr_cnt_q;
          t_d           = '0;
          if (!keep_state) h_d = '0;
          timeout_err_d = 1'b0;
          start_cnt_d   = '0;
          lstm_start_d  = 1'b1;
          busy_d        = 1'b1;
          state_d       = START;
        end
      end
      START: begin
        if (start_cnt_q == SCW'(START_CYCLES - 1)) begin
          lstm_start_d = 1'b0;
          wait_cnt_d   = '0;
          state_d      = WAIT;
        end else begin
          start_cnt_d = start_cnt_q + SCW'(1);
        end
      end
      WAIT: begin
        if (finished_edge) begin
          h_d = lstm_y_out;
          if (last_step) begin
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            t_d          = t_q + IW'(1);
            start_cnt_d  = '0;
            lstm_start_d = 1'b1;
            state_d      = START;
          end
        end else if (wait_cnt_q == WCW'(TIMEOUT - 1)) begin
          // Abort keeps the last captured h so a retry with keep_state can resume from it.
          timeout_err_d = 1'b1;
          wr_cnt_d      = '0;
          busy_d        = 1'b0;
          state_d       = IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + WCW'(1);
        end
      end
      DONE: begin
        done_d   = 1'b0;
        busy_d   = 1'b0;
        wr_cnt_d = '0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      wr_cnt_q      <= '0;
      len_q         <= '0;
      t_q           <= '0;
      h_q           <= '0;
      vec_buf_q     <= '{default: '0};
      start_cnt_q   <= '0;
      wait_cnt_q    <= '0;
      finished_q    <= 1'b0;
      lstm_start_q  <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_cnt_q      <= wr_cnt_d;
      len_q         <= len_d;
      t_q           <= t_d;
      h_q           <= h_d;
      vec_buf_q     <= vec_buf_d;
      start_cnt_q   <= start_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      finished_q    <= lstm_finished;
      lstm_start_q  <= lstm_start_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      timeout_err_q <= timeout_err_d;
    end
  end

endmodule

// File: tb/tb_lstm_seq_ctrl.sv
// Bench for lstm_seq_ctrl: a stub lstm (lanewise x+y_in after 20 cycles) and a
// queue-based model of the sequence and recurrent hidden state.
module tb_lstm_seq_ctrl;

  localparam int DW           = 8;
  localparam int LANES        = 4;
  localparam int MAX_LEN      = 8;
  localparam int START_CYCLES = 2;
  localparam int TIMEOUT      = 64;
  localparam int STUB_LAT     = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        seq_start;
  logic        keep_state;
  logic        busy;
  logic        done;
  logic        timeout_err;
  logic [31:0] h_out;
  logic        lstm_start;
  logic [31:0] lstm_x;
  logic [31:0] lstm_y_in;
  logic        lstm_finished;
  logic [31:0] lstm_y_out;

  int errors = 0;
  int checks = 0;

  logic [31:0] q[$];
  logic [31:0] h_m;

  int          stub_mode;
  int          stub_cnt;
  bit          stub_active;
  logic        stub_prev;
  logic [31:0] stub_sum;

  lstm_seq_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .seq_start     (seq_start),
    .keep_state    (keep_state),
    .busy          (busy),
    .done          (done),
    .timeout_err   (timeout_err),
    .h_out         (h_out),
    .lstm_start    (lstm_start),
    .lstm_x        (lstm_x),
    .lstm_y_in     (lstm_y_in),
    .lstm_finished (lstm_finished),
    .lstm_y_out    (lstm_y_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] lane_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < LANES; i++) r[i*DW +: DW] = a[i*DW +: DW] + b[i*DW +: DW];
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", tag, actual, expected);
    end
  endtask

  // Stub lstm: mode 0 normal, 1 never finishes, 2 holds a junk finished level first.
  always @(negedge clk) begin
    if (rst) begin
      stub_active   = 1'b0;
      stub_cnt      = 0;
      stub_prev     = 1'b0;
      lstm_finished = 1'b0;
      lstm_y_out    = '0;
    end else begin
      lstm_finished = 1'b0;
      if (lstm_start && !stub_prev) begin
        stub_active = 1'b1;
        stub_cnt    = 1;
        stub_sum    = lane_add(lstm_x, lstm_y_in);
      end else if (stub_active) begin
        stub_cnt++;
      end
      if (stub_active && stub_mode == 2 && stub_cnt < 10) begin
        lstm_finished = 1'b1;
        lstm_y_out    = 32'hDEADBEEF;
      end
      if (stub_active && stub_cnt == STUB_LAT) begin
        if (stub_mode != 1) begin
          lstm_finished = 1'b1;
          lstm_y_out    = stub_sum;
        end
        stub_active = 1'b0;
      end
      stub_prev = lstm_start;
    end
  end

  task automatic applyStimulus(input logic [31:0] data);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = data;
    #1;
    checkOutput("in_ready_load", 32'(in_ready), 32'(q.size() < MAX_LEN));
    if (q.size() < MAX_LEN) q.push_back(data);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic run_seq(input bit keep, input int mode, input bit poke);
    int   len, steps, done_cnt, busy_cycles, hi_cnt;
    bit   ended;
    logic prev;
    len = q.size();
    stub_mode = mode;
    if (!keep) h_m = '0;
    @(negedge clk);
    seq_start  = 1'b1;
    keep_state = keep;
    #1;
    checkOutput("in_ready_seq_start", 32'(in_ready), 32'd0);
    steps = 0; done_cnt = 0; busy_cycles = 0; hi_cnt = 0; ended = 1'b0; prev = 1'b0;
    for (int iter = 0; iter < 1000 && !ended; iter++) begin
      @(negedge clk);
      if (iter == 0) begin
        seq_start  = 1'b0;
        keep_state = 1'b0;
        checkOutput("timeout_cleared", 32'(timeout_err), 32'd0);
      end
      if (poke && iter == 6) seq_start = 1'b1;
      if (poke && iter == 7) begin
        checkOutput("in_ready_busy", 32'(in_ready), 32'd0);
        seq_start = 1'b0;
      end
      if (busy) busy_cycles++;
      if (done) done_cnt++;
      if (lstm_start) hi_cnt++;
      if (lstm_start && !prev) begin
        if (steps < len) begin
          checkOutput($sformatf("x_step%0d", steps), lstm_x, q[steps]);
          checkOutput($sformatf("y_in_step%0d", steps), lstm_y_in, h_m);
          if (mode != 1) h_m = lane_add(q[steps], h_m);
        end else begin
          checkOutput("extra_step", 32'(steps), 32'(len));
        end
        steps++;
      end
      if (!lstm_start && prev) begin
        checkOutput("start_width", 32'(hi_cnt), 32'(START_CYCLES));
        hi_cnt = 0;
      end
      prev = lstm_start;
      if (!busy && iter > 0) ended = 1'b1;
    end
    checkOutput("run_ends", 32'(busy), 32'd0);
    checkOutput("steps", 32'(steps), 32'((mode == 1) ? 1 : len));
    checkOutput("done_pulses", 32'(done_cnt), 32'((mode == 1) ? 0 : 1));
    checkOutput("timeout_err", 32'(timeout_err), 32'(mode == 1));
    checkOutput("h_out", h_out, h_m);
    if (mode == 1) checkOutput("timeout_cycles", 32'(busy_cycles), 32'(START_CYCLES + TIMEOUT));
    checkOutput("in_ready_after", 32'(in_ready), 32'd1);
    q.delete();
    stub_mode = 0;
  endtask

  task automatic reset_mid(input int wait_negs, input bit keep);
    int dones;
    applyStimulus($urandom());
    @(negedge clk);
    seq_start  = 1'b1;
    keep_state = keep;
    @(negedge clk);
    seq_start  = 1'b0;
    keep_state = 1'b0;
    repeat (wait_negs) @(negedge clk);
    if (wait_negs == 0) checkOutput("pre_reset_start", 32'(lstm_start), 32'd1);
    else checkOutput("pre_reset_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_lstm_start", 32'(lstm_start), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_h_out", h_out, 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_lstm_x", lstm_x, 32'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    q.delete();
    h_m = '0;
    dones = 0;
    repeat (STUB_LAT + 5) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    checkOutput("no_activity_after_reset", 32'(dones), 32'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; seq_start = 1'b0; keep_state = 1'b0;
    stub_mode = 0; h_m = '0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_timeout_err", 32'(timeout_err), 32'd0);
    checkOutput("reset_lstm_start", 32'(lstm_start), 32'd0);
    checkOutput("reset_h_out", h_out, 32'd0);
    rst = 1'b0;

    applyStimulus(32'hEBF53525);
    run_seq(1'b0, 0, 1'b0);

    applyStimulus(32'hEBF53525);
    applyStimulus(32'h5729BC2D);
    applyStimulus(32'h5545E122);
    run_seq(1'b0, 0, 1'b0);

    for (int n = 0; n < 4; n++) begin
      int len;
      len = $urandom_range(1, MAX_LEN);
      for (int k = 0; k < len; k++) applyStimulus($urandom());
      run_seq(1'($urandom_range(0, 1)), 0, 1'b0);
    end

    // One more than the buffer holds: the last write must be refused.
    for (int k = 0; k < MAX_LEN + 1; k++) applyStimulus($urandom());
    run_seq(1'b1, 0, 1'b1);

    @(negedge clk);
    seq_start = 1'b1;
    #1;
    checkOutput("empty_start_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    seq_start = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("empty_start_busy", 32'(busy), 32'd0);
    checkOutput("empty_start_lstm_start", 32'(lstm_start), 32'd0);

    applyStimulus($urandom());
    applyStimulus($urandom());
    run_seq(1'b1, 1, 1'b0);
    applyStimulus($urandom());
    run_seq(1'b1, 0, 1'b0);

    applyStimulus(32'h00000001);
    run_seq(1'b0, 0, 1'b0);
    applyStimulus(32'h00000001);
    run_seq(1'b1, 2, 1'b0);

    reset_mid(8, 1'b1);
    reset_mid(0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not reach its end");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

endmodule
